// File: rtl/multiport_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : multiport_reg_file_if
// Description : Bundles the write, read, issue-scoreboard and snapshot signals
//               of the multiport register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiport_reg_file_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRP  = 4
);
  localparam int AW = $clog2(NREG);

  logic [1:0]           we;
  logic [2*AW-1:0]      wa;
  logic [2*XLEN-1:0]    wd;
  logic [NRP*AW-1:0]    ra;
  logic [NRP*XLEN-1:0]  rd_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic [NREG-1:0]      busy;
  logic [NRP-1:0]       rd_busy;
  logic                 snap_req;
  logic                 snap_valid;
  logic [AW-1:0]        snap_idx;
  logic [XLEN-1:0]      snap_data;

  modport master (
    output we, wa, wd, ra, iss_valid, iss_rd, snap_req,
    input  rd_data, busy, rd_busy, snap_valid, snap_idx, snap_data
  );

  modport slave (
    input  we, wa, wd, ra, iss_valid, iss_rd, snap_req,
    output rd_data, busy, rd_busy, snap_valid, snap_idx, snap_data
  );
endinterface
`default_nettype wire

// File: rtl/multiport_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : multiport_reg_file
// Description : 2-write / NRP-read register file with x0 hardwired to zero,
//               optional write-to-read bypass, a per-register busy scoreboard
//               and a debug snapshot streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module multiport_reg_file #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRP    = 4,
  parameter int BYPASS = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  multiport_reg_file_if.slave     bus
);

  localparam int            AW         = $clog2(NREG);
  localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } snap_state_e;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  snap_state_e     state_q;
  snap_state_e     state_d;
  logic [AW-1:0]   snap_idx_q;
  logic [AW-1:0]   snap_idx_d;

  logic [AW-1:0]   w_wa    [2];
  logic [XLEN-1:0] w_wd    [2];
  logic [1:0]      w_wr_en;

  logic            w_snap_valid;
  logic [AW-1:0]   w_snap_idx;
  logic [XLEN-1:0] w_snap_data;

  // A write to x0 is dropped here so it neither stores nor clears busy.
  generate
    for (genvar k = 0; k < 2; k++) begin : g_wp
      assign w_wa[k]    = bus.wa[k*AW +: AW];
      assign w_wd[k]    = bus.wd[k*XLEN +: XLEN];
      assign w_wr_en[k] = bus.we[k] && (w_wa[k] != '0);
    end
  endgenerate

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int k = 0; k < 2; k++) begin
      if (w_wr_en[k]) begin
        regs_d[w_wa[k]] = w_wd[k];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  generate
    for (genvar j = 0; j < NRP; j++) begin : g_rp
      logic [AW-1:0]   w_ra;
      logic [1:0]      w_hit;
      logic [XLEN-1:0] w_rdata;

      assign w_ra = bus.ra[j*AW +: AW];

      for (genvar k = 0; k < 2; k++) begin : g_hit
        assign w_hit[k] = (BYPASS != 0) && w_wr_en[k] && (w_wa[k] == w_ra);
      end

      always_comb begin
        w_rdata = regs_q[w_ra];
        if (w_hit[0]) begin
          w_rdata = w_wd[0];
        end
        if (w_hit[1]) begin
          w_rdata = w_wd[1];
        end
      end

      assign bus.rd_data[j*XLEN +: XLEN] = w_rdata;
      // The forwarded value is the one the consumer was waiting on.
      assign bus.rd_busy[j]              = (|w_hit) ? 1'b0 : busy_q[w_ra];
    end
  endgenerate

  // Issue is applied after the write clears: a new producer keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++) begin
      if (w_wr_en[k]) begin
        busy_d[w_wa[k]] = 1'b0;
      end
    end
    if (bus.iss_valid && (bus.iss_rd != '0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_idx_d   = snap_idx_q;
    w_snap_valid = 1'b0;
    w_snap_idx   = '0;
    w_snap_data  = '0;
    case (state_q)
      IDLE: begin
        snap_idx_d = '0;
        if (bus.snap_req) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        w_snap_valid = 1'b1;
        w_snap_idx   = snap_idx_q;
        w_snap_data  = regs_q[snap_idx_q];
        if (snap_idx_q == c_last_idx) begin
          state_d    = IDLE;
          snap_idx_d = '0;
        end else begin
          snap_idx_d = snap_idx_q + AW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        snap_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_idx_q <= snap_idx_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.snap_valid = w_snap_valid;
  assign bus.snap_idx   = w_snap_idx;
  assign bus.snap_data  = w_snap_data;

endmodule
`default_nettype wire
